// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / block fill initiator for a single-port,
// word-addressed data memory, one memory access per cycle.
//
// Parameters:
//   AW       address width (word address)
//   DW       data width
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset    asynchronous active-high reset
//   start    request pulse, sampled only in IDLE
//   mode     0 = copy src->dst, 1 = fill dst with pattern
//   src      copy source base address
//   dst      destination base address
//   len      word count (0 .. 2^AW-1)
//   pattern  fill value
//   busy     high in every state except IDLE
//   done     one-cycle completion pulse
//   mem_we   memory write enable
//   mem_a    memory address
//   mem_wd   memory write data
//   mem_rd   memory read data (combinational from mem_a)
//
// mode, src, dst, len and pattern are captured with start and are
// don't-care at any other time.
module mem_copy_engine #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [1:0]    state_q, state_d;
  logic          mode_q,  mode_d;
  logic [AW-1:0] src_q,   src_d;
  logic [AW-1:0] dst_q,   dst_d;
  logic [AW-1:0] rem_q,   rem_d;
  logic [DW-1:0] pat_q,   pat_d;
  logic [DW-1:0] data_q,  data_d;

  // Next-state logic. Pointers wrap modulo 2^AW with no special handling.
  // In copy mode every word is read and then written before the next
  // read, so overlapping regions behave as a strict ascending copy.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          src_d  = src;
          dst_d  = dst;
          rem_d  = len;
          pat_d  = pattern;
          if (len == '0) begin
            state_d = S_DONE;
          end else if (mode) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        data_d  = mem_rd;
        src_d   = src_q + ONE;
        state_d = S_WR;
      end
      S_WR: begin
        dst_d = dst_q + ONE;
        rem_d = rem_q - ONE;
        if (rem_q == ONE) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
    end
  end

  // Moore outputs: decoded from state only, so an asynchronous reset
  // drops mem_we in the same cycle it is asserted.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    mem_we = (state_q == S_WR);
    mem_a  = '0;
    mem_wd = '0;
    unique case (state_q)
      S_RD: begin
        mem_a = src_q;
      end
      S_WR: begin
        mem_a  = dst_q;
        mem_wd = mode_q ? pat_q : data_q;
      end
      default: begin
        mem_a  = '0;
        mem_wd = '0;
      end
    endcase
  end

endmodule
